// File: rtl/psum_accumulator.sv
// psum_accumulator: groups signed products into dot-product partial sums.
// Define PSUM_ACC_SAT_EN to clamp on overflow instead of wrapping.
module psum_accumulator #(
    parameter int W_IN  = 24,
    parameter int W_ACC = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_ACC-1:0] out_sum,
    output logic             out_ovf
);

    localparam int MSB = W_ACC - 1;
    localparam logic [W_ACC-1:0] SAT_MAX = {1'b0, {MSB{1'b1}}};
    localparam logic [W_ACC-1:0] SAT_MIN = {1'b1, {MSB{1'b0}}};
    localparam logic [LEN_W:0]   ONE     = (LEN_W+1)'(1);

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [LEN_W:0]   r_len;
    logic [LEN_W:0]   r_cnt;
    logic [W_ACC-1:0] r_acc;
    logic             r_ovf;

    logic             r_out_valid;
    logic [W_ACC-1:0] r_out_sum;
    logic             r_out_ovf;

    logic             w_first;
    logic [LEN_W:0]   w_cfg_len;
    logic [LEN_W:0]   w_len_eff;
    logic [LEN_W:0]   w_cnt_nxt;
    logic             w_last;
    logic             w_accept;
    logic             w_done;

    logic [W_ACC-1:0] w_prod_ext;
    logic [W_ACC-1:0] w_sum;
    logic             w_ovf_add;
    logic [W_ACC-1:0] w_acc_add;
    logic [W_ACC-1:0] w_acc_nxt;
    logic             w_ovf_nxt;

    // The first beat of a group samples cfg_len; later beats use the latched length.
    assign w_first   = (r_state == ST_IDLE);
    assign w_cfg_len = {1'b0, cfg_len};
    assign w_len_eff = w_first ? ((cfg_len == '0) ? ONE : w_cfg_len) : r_len;
    assign w_cnt_nxt = w_first ? ONE : (r_cnt + ONE);
    assign w_last    = (w_cnt_nxt == w_len_eff);

    // Only a completing beat needs a free result register.
    assign in_ready = !rst && !(w_last && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_done   = w_accept && w_last;

    assign w_prod_ext = W_ACC'($signed(in_prod));
    assign w_sum      = r_acc + w_prod_ext;
    assign w_ovf_add  = (r_acc[MSB] == w_prod_ext[MSB]) &&
                        (w_sum[MSB] != r_acc[MSB]);

`ifdef PSUM_ACC_SAT_EN
    assign w_acc_add = w_ovf_add ? (r_acc[MSB] ? SAT_MIN : SAT_MAX) : w_sum;
`else
    assign w_acc_add = w_sum;
`endif

    assign w_acc_nxt = w_first ? w_prod_ext : w_acc_add;
    assign w_ovf_nxt = w_first ? 1'b0 : (r_ovf | w_ovf_add);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_last) begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_len <= w_len_eff;
            r_ovf <= w_ovf_nxt;
        end
    end

    // A completion in the same cycle as a drain reloads the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_done) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_nxt;
            r_out_ovf   <= w_ovf_nxt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed vectors for psum_accumulator.
// Runs a 32-bit and a 24-bit accumulator side by side on shared inputs.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_len = '0;
    logic        in_valid = 1'b0;
    logic [23:0] in_prod = '0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        out_ovf;

    logic        w_rdy24;
    logic        w_vld24;
    logic [23:0] w_sum24;
    logic        w_ovf24;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [31:0] q_sum[$];
    logic        q_ovf[$];
    int          q_cyc[$];
    logic [23:0] q24_sum[$];
    logic        q24_ovf[$];

    psum_accumulator #(.W_IN(24), .W_ACC(32), .LEN_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    psum_accumulator #(.W_IN(24), .W_ACC(24), .LEN_W(8)) u_dut24 (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (w_rdy24),
        .in_prod   (in_prod),
        .out_valid (w_vld24),
        .out_ready (out_ready),
        .out_sum   (w_sum24),
        .out_ovf   (w_ovf24)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_sum.push_back(out_sum);
            q_ovf.push_back(out_ovf);
            q_cyc.push_back(cyc);
        end
        if (!rst && w_vld24 && out_ready) begin
            q24_sum.push_back(w_sum24);
            q24_ovf.push_back(w_ovf24);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Holds the beat until accepted; returns the number of stalled cycles.
    task automatic send(input logic [23:0] p, input logic [7:0] l,
                        output int stalls);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_prod  = p;
        cfg_len  = l;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) n++;
        end
        stalls   = n;
        last_acc = cyc;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        q_sum.delete();
        q_ovf.delete();
        q_cyc.delete();
        q24_sum.delete();
        q24_ovf.delete();
    endtask

    initial begin
        int s, s1, s2, s3, s4;
        int a1, a2;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic 4-beat dot product.
        out_ready = 1'b1;
        clear_q();
        send(24'd100, 8'd4, s);
        send(24'(-50), 8'd4, s);
        send(24'd7, 8'd4, s);
        send(24'(-1), 8'd4, s);
        a1 = last_acc;
        idle(4);
        chk("t1_count", q_sum.size(), 32'd1);
        chk("t1_sum", q_sum[0], 32'd56);
        chk("t1_ovf", {31'd0, q_ovf[0]}, 32'd0);
        chk("t1_latency", q_cyc[0], a1);

        // len 0 treated as 1, followed back-to-back by len 1.
        clear_q();
        send(24'h800000, 8'd0, s1);
        a1 = last_acc;
        send(24'd3, 8'd1, s2);
        a2 = last_acc;
        idle(4);
        chk("t2_count", q_sum.size(), 32'd2);
        chk("t2_sum0", q_sum[0], 32'hFF800000);
        chk("t2_sum1", q_sum[1], 32'd3);
        chk("t2_lat0", q_cyc[0], a1);
        chk("t2_lat1", q_cyc[1], a2);
        chk("t2_no_bubble", a2 - a1, 32'd1);
        chk("t2_no_stall", s1 + s2, 32'd0);

        // Backpressure only stalls the completing beat.
        clear_q();
        out_ready = 1'b0;
        fork
            begin
                send(24'd1, 8'd2, s1);
                send(24'd2, 8'd2, s2);
                send(24'd3, 8'd2, s3);
                chk("t3_held_valid", {31'd0, out_valid}, 32'd1);
                chk("t3_held_sum", out_sum, 32'd3);
                send(24'd4, 8'd2, s4);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("t3_early_stalls", s1 + s2 + s3, 32'd0);
        chk("t3_final_stalled", {31'd0, s4 > 0}, 32'd1);
        chk("t3_count", q_sum.size(), 32'd2);
        chk("t3_sum0", q_sum[0], 32'd3);
        chk("t3_sum1", q_sum[1], 32'd7);

        // Positive then negative overflow.
        clear_q();
        send(24'h7FFFFF, 8'd2, s);
        send(24'd1, 8'd2, s);
        send(24'h800000, 8'd2, s);
        send(24'hFFFFFF, 8'd2, s);
        idle(4);
        chk("t4_count32", q_sum.size(), 32'd2);
        chk("t4_sum32_pos", q_sum[0], 32'h00800000);
        chk("t4_ovf32_pos", {31'd0, q_ovf[0]}, 32'd0);
        chk("t4_sum32_neg", q_sum[1], 32'hFF7FFFFF);
        chk("t4_count24", q24_sum.size(), 32'd2);
`ifdef PSUM_ACC_SAT_EN
        chk("t4_sum24_pos", {8'd0, q24_sum[0]}, 32'h007FFFFF);
        chk("t4_sum24_neg", {8'd0, q24_sum[1]}, 32'h00800000);
`else
        chk("t4_sum24_pos", {8'd0, q24_sum[0]}, 32'h00800000);
        chk("t4_sum24_neg", {8'd0, q24_sum[1]}, 32'h007FFFFF);
`endif
        chk("t4_ovf24_pos", {31'd0, q24_ovf[0]}, 32'd1);
        chk("t4_ovf24_neg", {31'd0, q24_ovf[1]}, 32'd1);

        // Reset discards a held result and an open group.
        clear_q();
        out_ready = 1'b0;
        send(24'd9, 8'd1, s);
        send(24'd10, 8'd4, s);
        send(24'd20, 8'd4, s);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_valid_cleared", {31'd0, out_valid}, 32'd0);
        chk("t5_sum_cleared", out_sum, 32'd0);
        out_ready = 1'b1;
        send(24'd5, 8'd2, s);
        send(24'd6, 8'd2, s);
        idle(4);
        chk("t5_count", q_sum.size(), 32'd1);
        chk("t5_sum", q_sum[0], 32'd11);

        // Long group; mid-group cfg_len change is ignored.
        clear_q();
        send(24'd1, 8'd255, s);
        for (int i = 0; i < 254; i++) begin
            send(24'd1, 8'd3, s);
        end
        idle(4);
        chk("t6_count", q_sum.size(), 32'd1);
        chk("t6_sum", q_sum[0], 32'd255);
        chk("t6_ovf", {31'd0, q_ovf[0]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
